// File: rtl/iob_ram_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// iob_ram_rmw_ctrl
//
// Native-bus front end for a dual-port SRAM wrapper (port A read/write, port B
// read-only, one-cycle read latency). The macro behind the wrapper performs
// full-word writes only, so byte-strobed writes are done as read-modify-write:
// old word read on port B, bytes merged, full word written on port A.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_addr              word address
//   req_wdata/req_wstrb   write data and byte strobes (strobes == 0 means read)
//   rsp_valid             one-cycle response pulse, one per accepted request
//   rsp_rdata             read data (0 for write responses)
//   ram_enA/ram_weA       port A enable and write enable (all-ones when writing)
//   ram_addrA/ram_dinA    port A address and write data (0 when not writing)
//   ram_doutA             port A read data (not used)
//   ram_addrB/ram_doutB   port B read address and read data
// -----------------------------------------------------------------------------
module iob_ram_rmw_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  req_ready,

    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,

    output logic                  ram_enA,
    output logic [DATA_W/8-1:0]   ram_weA,
    output logic [ADDR_W-1:0]     ram_addrA,
    output logic [DATA_W-1:0]     ram_dinA,
    input  logic [DATA_W-1:0]     ram_doutA,
    output logic [ADDR_W-1:0]     ram_addrB,
    input  logic [DATA_W-1:0]     ram_doutB
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [0:0] {
        StIdle,
        StMerge
    } state_e;

    state_e              state_q, state_d;

    // Pending partial write, captured in the accept cycle and used in StMerge.
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    // Response pipeline: rsp_read_q selects read data vs. zero for writes.
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_read_q, rsp_read_d;

    // Port B returns garbage when it reads the address port A writes in the
    // same cycle; remember that write so its data can stand in for port B.
    logic                wr_hit_q, wr_hit_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic [DATA_W-1:0]   fwd_data;
    logic [DATA_W-1:0]   merged;

    logic                is_read;
    logic                is_full;

    logic                unused_douta;
    assign unused_douta = ^ram_doutA;

    // Data returned by the port B read issued in the previous cycle.
    assign fwd_data = wr_hit_q ? wr_data_q : ram_doutB;

    always_comb begin
        merged = fwd_data;
        for (int i = 0; i < STRB_W; i++) begin
            if (wstrb_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    assign is_read = (req_wstrb == '0);
    assign is_full = &req_wstrb;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_read_d  = 1'b0;

        req_ready   = 1'b0;
        ram_enA     = 1'b0;
        ram_weA     = '0;
        ram_addrA   = '0;
        ram_dinA    = '0;
        // Port B always follows the bus address so a read issues in its
        // accept cycle without any extra registering.
        ram_addrB   = req_addr;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (is_read) begin
                        rsp_valid_d = 1'b1;
                        rsp_read_d  = 1'b1;
                    end else if (is_full) begin
                        ram_enA     = 1'b1;
                        ram_weA     = '1;
                        ram_addrA   = req_addr;
                        ram_dinA    = req_wdata;
                        rsp_valid_d = 1'b1;
                    end else begin
                        // Old word is being read on port B right now.
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        wstrb_d = req_wstrb;
                        state_d = StMerge;
                    end
                end
            end

            StMerge: begin
                ram_enA     = 1'b1;
                ram_weA     = '1;
                ram_addrA   = addr_q;
                ram_dinA    = merged;
                rsp_valid_d = 1'b1;
                state_d     = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Reset also squashes a write in flight, including one in StMerge.
        if (rst) begin
            req_ready = 1'b0;
            ram_enA   = 1'b0;
            ram_weA   = '0;
            ram_addrA = '0;
            ram_dinA  = '0;
        end
    end

    assign wr_hit_d  = ram_enA & (ram_addrB == ram_addrA);
    assign wr_data_d = ram_dinA;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_read_q  <= 1'b0;
            wr_hit_q    <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_read_q  <= rsp_read_d;
            wr_hit_q    <= wr_hit_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_read_q ? fwd_data : '0;

endmodule

// File: tb/tb_iob_ram_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iob_ram_rmw_ctrl
//
// Directed and random stimulus for iob_ram_rmw_ctrl, with a behavioural
// dual-port RAM (port B returns junk on a same-address write collision) and a
// word-level reference memory used to predict every response.
// -----------------------------------------------------------------------------
module tb_iob_ram_rmw_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          ram_enA;
    logic [SW-1:0] ram_weA;
    logic [AW-1:0] ram_addrA;
    logic [DW-1:0] ram_dinA;
    logic [DW-1:0] ram_doutA;
    logic [AW-1:0] ram_addrB;
    logic [DW-1:0] ram_doutB;

    iob_ram_rmw_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_enA   (ram_enA),
        .ram_weA   (ram_weA),
        .ram_addrA (ram_addrA),
        .ram_dinA  (ram_dinA),
        .ram_doutA (ram_doutA),
        .ram_addrB (ram_addrB),
        .ram_doutB (ram_doutB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: full-word write on any nonzero weA, 1-cycle reads.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            ram_doutA <= '0;
            ram_doutB <= '0;
        end else begin
            if (ram_enA && ram_weA != '0) mem[ram_addrA] <= ram_dinA;
            if (ram_enA && ram_weA != '0 && ram_addrA == ram_addrB)
                ram_doutB <= 32'hBAD0_BAD0;
            else
                ram_doutB <= mem[ram_addrB];
            ram_doutA <= mem[ram_addrA];
        end
    end

    int            checks;
    int            errors;
    int            acc_cnt;
    int            rsp_cnt;
    int            wr_exp;
    int            wr_seen;
    bit            mon_en;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard duties, run once per cycle between clock edges.
    task automatic mon();
        logic [DW-1:0] e;
        logic [DW-1:0] w;
        if (rst || !mon_en) return;
        if (rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check("rsp_orphan", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e);
            end
        end
        check("wea_shape", 32'(ram_weA), ram_enA ? 32'hF : 32'h0);
        if (ram_enA) wr_seen++;
        if (req_valid && req_ready) begin
            acc_cnt++;
            if (req_wstrb == '0) begin
                exp_q.push_back(ref_mem[req_addr]);
            end else begin
                w = ref_mem[req_addr];
                for (int b = 0; b < SW; b++)
                    if (req_wstrb[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
                ref_mem[req_addr] = w;
                exp_q.push_back('0);
                wr_exp++;
            end
        end
    endtask

    // Leaves the bench at 2 time units after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
    endtask

    // Present a request and hold it until accepted (bounded wait).
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s);
        int n;
        drive(a, d, s);
        #1;
        n = 0;
        while (!req_ready && n < 8) begin
            cycle();
            #1;
            n++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        cycle();
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic [SW-1:0] rs;

        checks  = 0;
        errors  = 0;
        acc_cnt = 0;
        rsp_cnt = 0;
        wr_exp  = 0;
        wr_seen = 0;
        mon_en  = 1'b1;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        rst     = 1'b1;
        mem_clr = 1'b1;
        idle();

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #3;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_ena", 32'(ram_enA), 32'd0);
        check("rst_wea", 32'(ram_weA), 32'h0);
        rst     = 1'b0;
        mem_clr = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_addra", 32'(ram_addrA), 32'h0);
        check("idle_dina", ram_dinA, 32'h0);
        @(posedge clk);
        #2;

        // Full write then read of 0x005
        drive(10'h005, 32'hDEADBEEF, 4'hF);
        #1;
        check("t1_ena", 32'(ram_enA), 32'd1);
        check("t1_wea", 32'(ram_weA), 32'hF);
        check("t1_addra", 32'(ram_addrA), 32'h005);
        check("t1_dina", ram_dinA, 32'hDEADBEEF);
        cycle();
        drive(10'h005, 32'h0, 4'h0);
        #1;
        check("t1_wrsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_wrsp_rdata", rsp_rdata, 32'h0);
        check("t1_ena_once", 32'(ram_enA), 32'd0);
        check("t1_addrb", 32'(ram_addrB), 32'h005);
        cycle();
        idle();
        #1;
        check("t1_rrsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rrsp_rdata", rsp_rdata, 32'hDEADBEEF);
        cycle();
        #1;
        check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);

        // Partial write merge on 0x010, with a read held off during merge
        drive(10'h010, 32'h11223344, 4'hF);
        #1;
        cycle();
        drive(10'h010, 32'hAABBCCDD, 4'b0101);
        #1;
        check("t2_acc_ready", 32'(req_ready), 32'd1);
        check("t2_acc_ena", 32'(ram_enA), 32'd0);
        check("t2_acc_addrb", 32'(ram_addrB), 32'h010);
        cycle();
        drive(10'h010, 32'h0, 4'h0);
        #1;
        check("t2_mrg_ready", 32'(req_ready), 32'd0);
        check("t2_mrg_ena", 32'(ram_enA), 32'd1);
        check("t2_mrg_wea", 32'(ram_weA), 32'hF);
        check("t2_mrg_addra", 32'(ram_addrA), 32'h010);
        check("t2_mrg_dina", ram_dinA, 32'h11BB33DD);
        check("t2_mrg_rsp", 32'(rsp_valid), 32'd0);
        cycle();
        #1;
        check("t2_wrsp_valid", 32'(rsp_valid), 32'd1);
        check("t2_wrsp_rdata", rsp_rdata, 32'h0);
        check("t2_ready_back", 32'(req_ready), 32'd1);
        cycle();
        idle();
        #1;
        check("t2_rd_valid", 32'(rsp_valid), 32'd1);
        check("t2_rd_rdata", rsp_rdata, 32'h11BB33DD);
        cycle();

        // Write / read / write / read on 0x020, back to back
        drive(10'h020, 32'hCAFEF00D, 4'hF);
        #1;
        cycle();
        drive(10'h020, 32'h0, 4'h0);
        #1;
        cycle();
        drive(10'h020, 32'h12345678, 4'hF);
        #1;
        check("t3_rd1", rsp_rdata, 32'hCAFEF00D);
        cycle();
        drive(10'h020, 32'h0, 4'h0);
        #1;
        check("t3_wrsp", rsp_rdata, 32'h0);
        cycle();
        idle();
        #1;
        check("t3_rd2", rsp_rdata, 32'h12345678);
        cycle();

        // Back-to-back partial writes to 0x030
        drive(10'h030, 32'h000000FF, 4'b0001);
        #1;
        cycle();
        drive(10'h030, 32'h0000EE00, 4'b0010);
        #1;
        check("t4_stall", 32'(req_ready), 32'd0);
        check("t4_mrg1_dina", ram_dinA, 32'h000000FF);
        cycle();
        #1;
        check("t4_ready", 32'(req_ready), 32'd1);
        check("t4_no_wr", 32'(ram_enA), 32'd0);
        cycle();
        idle();
        #1;
        check("t4_mrg2_ena", 32'(ram_enA), 32'd1);
        check("t4_mrg2_dina", ram_dinA, 32'h0000EEFF);
        cycle();
        send(10'h030, 32'h0, 4'h0);
        idle();
        #1;
        check("t4_rd", rsp_rdata, 32'h0000EEFF);
        cycle();

        // Reset during merge of a partial write to 0x040
        send(10'h040, 32'h55555555, 4'hF);
        idle();
        cycle();
        mon_en = 1'b0;
        drive(10'h040, 32'h0, 4'b0011);
        #1;
        cycle();
        idle();
        rst = 1'b1;
        #1;
        check("t5_rst_ena", 32'(ram_enA), 32'd0);
        check("t5_rst_wea", 32'(ram_weA), 32'h0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        check("t5_rst_rsp", 32'(rsp_valid), 32'd0);
        cycle();
        #1;
        check("t5_rst2_rsp", 32'(rsp_valid), 32'd0);
        check("t5_rst2_ena", 32'(ram_enA), 32'd0);
        rst = 1'b0;
        #1;
        check("t5_rel_ready", 32'(req_ready), 32'd1);
        cycle();
        mon_en = 1'b1;
        #1;
        check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        send(10'h040, 32'h0, 4'h0);
        idle();
        #1;
        check("t5_rd", rsp_rdata, 32'h55555555);
        cycle();

        // Random mix on a small address window
        for (int k = 0; k < 100; k++) begin
            ra = 10'h100 + 10'($urandom_range(0, 7));
            rd = $urandom;
            case ($urandom_range(0, 2))
                0:       rs = 4'h0;
                1:       rs = 4'hF;
                default: rs = 4'($urandom_range(1, 14));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                idle();
                cycle();
            end
            send(ra, rd, rs);
        end
        idle();
        repeat (4) cycle();

        check("drain", 32'(exp_q.size()), 32'd0);
        check("rsp_count", 32'(rsp_cnt), 32'(acc_cnt));
        check("wr_count", 32'(wr_seen), 32'(wr_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
